// File: rtl/mem_access_ctrl.sv
// CPU-to-RAM access sequencer: byte/half/word loads and stores over a single-port
// word RAM, with alignment checking and read-modify-write for sub-word stores.
//   state | meaning
//   IDLE  | waiting for i_req; request latched and checked here
//   READ  | RAM read cycle (load data or RMW source word)
//   WRITE | RAM write cycle, DUT drives io_mem_data
//   RESP  | one-cycle o_ready pulse, o_err valid
module mem_access_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_sign_ext,
    input  logic [ADDR_W+1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_ready,
    output logic              o_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    inout  wire  [31:0]       io_mem_data,
    output logic              o_mem_rw,
    output logic              o_mem_cs
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_off;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [31:0]         r_rmw;
    logic [31:0]         r_rdata;
    logic [ADDR_W-1:0]   r_mem_addr;

    logic                w_bad;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_ld_data;
    logic [31:0]         w_wr_data;

    assign w_bad = (i_size == 2'b11)
                 | ((i_size == 2'b01) & i_addr[0])
                 | ((i_size == 2'b10) & (i_addr[1:0] != 2'b00));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if (w_bad)
                        w_state_nxt = ST_RESP;
                    else if (i_we && (i_size == 2'b10))
                        w_state_nxt = ST_WRITE;
                    else
                        w_state_nxt = ST_READ;
                end
            end
            ST_READ:  w_state_nxt = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Little-endian lane selection straight off the RAM bus for loads
    assign w_byte = io_mem_data[{r_off, 3'b000} +: 8];
    assign w_half = io_mem_data[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = io_mem_data;
        case (r_size)
            2'b00:   w_ld_data = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_ld_data = {{16{r_sext & w_half[15]}}, w_half};
            default: w_ld_data = io_mem_data;
        endcase
    end

    always_comb begin
        w_wr_data = r_wdata;
        case (r_size)
            2'b00: begin
                w_wr_data = r_rmw;
                w_wr_data[{r_off, 3'b000} +: 8] = r_wdata[7:0];
            end
            2'b01: begin
                w_wr_data = r_rmw;
                w_wr_data[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: w_wr_data = r_wdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_off      <= 2'b00;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_sext     <= 1'b0;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            r_rmw      <= 32'h0;
            r_rdata    <= 32'h0;
            r_mem_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_off   <= i_addr[1:0];
                        r_we    <= i_we;
                        r_size  <= i_size;
                        r_sext  <= i_sign_ext;
                        r_wdata <= i_wdata;
                        r_err   <= w_bad;
                        // rejected accesses leave the RAM address untouched
                        if (!w_bad)
                            r_mem_addr <= i_addr[ADDR_W+1:2];
                    end
                end
                ST_READ: begin
                    if (r_we)
                        r_rmw <= io_mem_data;
                    else
                        r_rdata <= w_ld_data;
                end
                default: ;
            endcase
        end
    end

    assign o_ready     = (r_state == ST_RESP);
    assign o_err       = (r_state == ST_RESP) & r_err;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_mem_cs    = (r_state == ST_READ) | (r_state == ST_WRITE);
    assign o_mem_rw    = (r_state == ST_WRITE);
    assign o_mem_addr  = r_mem_addr;
    assign o_rdata     = r_rdata;
    assign io_mem_data = (r_state == ST_WRITE) ? w_wr_data : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a RAM model on the bidirectional bus, an
// arithmetic reference model for expected results, and a negedge monitor.
module tb_mem_access_ctrl;
    localparam int AW = 12;

    typedef struct {
        int          rdy_cyc;
        bit          err;
        logic [31:0] rdata;
        int          widx;
        logic [31:0] wexp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req;
    logic            we;
    logic [1:0]      size;
    logic            sext;
    logic [AW+1:0]   addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            ready;
    logic            err;
    logic            busy;
    logic [AW-1:0]   mem_addr;
    wire  [31:0]     mem_data;
    logic            mem_rw;
    logic            mem_cs;

    logic [31:0]     ram     [0:(1<<AW)-1];
    logic [31:0]     exp_mem [0:(1<<AW)-1];
    exp_t            sbq[$];
    int              n_vec;
    int              n_fail;
    int              cyc;
    bit              cs_seen;
    logic [31:0]     rdata_exp;

    mem_access_ctrl #(.ADDR_W(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_size      (size),
        .i_sign_ext  (sext),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_ready     (ready),
        .o_err       (err),
        .o_busy      (busy),
        .o_mem_addr  (mem_addr),
        .io_mem_data (mem_data),
        .o_mem_rw    (mem_rw),
        .o_mem_cs    (mem_cs)
    );

    // RAM drives the bus whenever it is in read direction
    assign mem_data = mem_rw ? 32'hzzzz_zzzz : ram[mem_addr];

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h8899AABB;
        return 32'(i * 32'h9E3779B9) ^ 32'h5BD1E995;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Reference model: byte-lane arithmetic on a 64-bit scratch value
    task automatic model(input logic w, input logic [1:0] sz, input logic s,
                         input logic [AW+1:0] a, input logic [31:0] wd,
                         output int lat, output exp_t e);
        int     off;
        int     widx;
        int     nb;
        longint word;
        longint mask;
        longint val;
        bit     bad;
        off  = int'(a[1:0]);
        widx = int'(a[AW+1:2]);
        word = longint'({32'd0, exp_mem[widx]});
        bad  = (sz == 2'd3) || (sz == 2'd1 && (off % 2) == 1) || (sz == 2'd2 && off != 0);
        nb   = 1 << sz;
        mask = (64'sd1 << (8 * nb)) - 1;
        if (bad) begin
            lat = 1;
        end else if (!w) begin
            val = (word >> (8 * off)) & mask;
            if (s && val >= (mask + 1) / 2)
                val = val - (mask + 1);
            rdata_exp = val[31:0];
            lat = 2;
        end else begin
            val = (word & ~(mask << (8 * off))) | ((longint'({32'd0, wd}) & mask) << (8 * off));
            exp_mem[widx] = val[31:0];
            lat = (sz == 2'd2) ? 2 : 3;
        end
        e.rdy_cyc = cyc + lat;
        e.err     = bad;
        e.rdata   = rdata_exp;
        e.widx    = widx;
        e.wexp    = exp_mem[widx];
    endtask

    task automatic scramble(input bit hold);
        we    = 1'($urandom);
        size  = 2'($urandom);
        sext  = 1'($urandom);
        addr  = (AW+2)'($urandom);
        wdata = $urandom;
        req   = hold ? 1'b1 : 1'($urandom);
    endtask

    // Called on a negedge while the DUT is idle; returns on the negedge of the next idle cycle
    task automatic issue(input logic w, input logic [1:0] sz, input logic s,
                         input logic [AW+1:0] a, input logic [31:0] wd, input bit hold);
        int   lat;
        exp_t e;
        req = 1'b1; we = w; size = sz; sext = s; addr = a; wdata = wd;
        model(w, sz, s, a, wd, lat, e);
        sbq.push_back(e);
        repeat (lat) begin
            @(negedge clk);
            scramble(hold);
        end
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},    ready, 0);
        chk({tag, "_err"},      err, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_cs"},       mem_cs, 0);
        chk({tag, "_rw"},       mem_rw, 0);
        chk({tag, "_rdata"},    rdata, 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_data_hiz"}, mem_data, ram[mem_addr]);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_cs) cs_seen = 1'b1;
                if (mem_rw) begin
                    chk("cs_with_rw", mem_cs, 1);
                    chk("busy_with_rw", busy, 1);
                end else begin
                    chk("mem_data_not_driven", mem_data, ram[mem_addr]);
                end
                if (!busy) chk("cs_in_idle", mem_cs, 0);
                if (sbq.size() != 0 && cyc > sbq[0].rdy_cyc) begin
                    chk("ready_missing_cycle", cyc, sbq[0].rdy_cyc);
                    void'(sbq.pop_front());
                end
                if (ready) begin
                    chk("ready_expected", 32'(sbq.size() != 0), 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("ready_cycle", cyc, e.rdy_cyc);
                        chk("err", err, e.err);
                        chk("rdata", rdata, e.rdata);
                        chk("ram_word", ram[e.widx], e.wexp);
                        chk("ram_cycle_used", cs_seen, !e.err);
                    end
                    cs_seen = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [1:0]    sz;
        logic [AW+1:0] a;
        n_vec = 0; n_fail = 0; cyc = 0; cs_seen = 1'b0; rdata_exp = 32'h0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = init_word(i);
            exp_mem[i] = init_word(i);
        end
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = '0; wdata = 32'h0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
                if (mem_cs && mem_rw) ram[mem_addr] = mem_data;
            end
            monitor();
        join_none

        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap(2);

        issue(1'b0, 2'b00, 1'b1, 14'h017, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 14'h014, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 14'h015, 32'h0000_005A, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 14'h014, 32'h0, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 14'h012, 32'hCAFE_F00D, 1'b0);
        issue(1'b1, 2'b11, 1'b0, 14'h014, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 14'h013, 32'h0, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 14'h016, 32'h1234_FEDC, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 14'h016, 32'h0, 1'b0);
        gap(1);

        for (int i = 0; i < 6; i++)
            issue(1'b0, 2'($urandom_range(0, 2)), 1'($urandom), 14'($urandom_range(0, 31) * 4),
                  32'h0, 1'b1);
        gap(1);

        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 14'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom));
            gap($urandom_range(0, 2));
        end
        gap(2);

        req = 1'b1; we = 1'b1; size = 2'b10; sext = 1'b0; addr = 14'h020; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("abort_in_write", mem_rw, 1);
        req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        rdata_exp = 32'h0;
        cs_seen   = 1'b0;
        chk_reset_outputs("abort");
        @(negedge clk);
        chk_reset_outputs("abort_hold");
        rst_n = 1'b1;
        gap(4);
        chk("abort_ram8", ram[8], exp_mem[8]);

        for (int i = 0; i < 20; i++) begin
            issue(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
                  14'($urandom_range(0, 15) * 4), $urandom, 1'b0);
        end
        issue(1'b0, 2'b10, 1'b0, 14'h020, 32'h0, 1'b0);
        gap(5);
        chk("queue_drained", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 12, word-address width presented to the RAM; byte address width is ADDR_W+2.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  asynchronous, active-low reset.
REQ-004 req  in  1  CPU access request; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 sign_ext  in  1  loads only: 1 = sign-extend sub-word data, 0 = zero-extend.
REQ-008 addr  in  ADDR_W+2  byte address.
REQ-009 wdata  in  32  store data, right-aligned for byte/half.
REQ-010 rdata  out  32  load result, extended.
REQ-011 ready  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with ready; 1 = access rejected.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 mem_addr  out  ADDR_W  RAM word address.
REQ-015 mem_data  inout  32  RAM data bus.
REQ-016 mem_rw  out  1  RAM direction: 1 = write, 0 = read; the RAM drives mem_data whenever mem_rw=0.
REQ-017 mem_cs  out  1  RAM chip select.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE and RESP.
REQ-019 In IDLE with req=1, the block SHALL latch addr, we, size, sign_ext and wdata; later changes on these inputs SHALL be ignored until the next IDLE.
REQ-020 Each access SHALL be checked in IDLE: size=11, half with addr[0]=1, or word with addr[1:0]!=00 -> go to RESP with err=1; no RAM cycle (mem_cs stays 0).
REQ-021 Load: IDLE->READ->RESP; READ drives mem_cs=1, mem_rw=0, mem_addr=addr[ADDR_W+1:2], and the closing edge SHALL capture mem_data.
REQ-022 Word store: IDLE->WRITE->RESP; WRITE drives mem_cs=1, mem_rw=1, mem_data=wdata.
REQ-023 Byte/half store SHALL be read-modify-write: IDLE->READ->WRITE->RESP; the word captured in READ SHALL have only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
REQ-024 Lanes SHALL be little-endian: byte offset k occupies bits 8k+7:8k; a half at offset 2 occupies bits 31:16.
REQ-025 Load extraction SHALL select the addressed lane and extend it to 32 bits per sign_ext; a word load SHALL return the word unchanged.
REQ-026 In RESP, ready=1 for exactly one cycle, then IDLE; err=0 except for the REQ-020 case.
REQ-027 Latency from req sampled to ready high SHALL be: error 1 cycle, word store 2, load 2, sub-word store 3.
REQ-028 rdata SHALL update only on successful load completion and SHALL hold otherwise, including across stores and errors.
REQ-029 mem_data SHALL be driven only while in WRITE and SHALL be high-Z in every other state (no contention with the RAM read driver).
REQ-030 mem_rw SHALL be 1 only in WRITE; mem_cs SHALL be 0 in IDLE and RESP.
REQ-031 req high during READ, WRITE or RESP SHALL NOT be accepted; the earliest next acceptance is the IDLE cycle after RESP.
REQ-032 mem_addr SHALL hold its last value outside READ/WRITE.

Reset
REQ-033 Rst=0 SHALL immediately force IDLE, ready=0, err=0, busy=0, rdata=0, mem_addr=0, mem_cs=0, mem_rw=0 and mem_data high-Z, independent of CLK.
REQ-034 Reset asserted during READ or WRITE SHALL abort the access: no RAM write on that edge and no ready pulse after release.

Verification
REQ-035 RAM[5]=0x8899AABB; load byte addr=0x017, sign_ext=1 -> ready 2 cycles later, rdata=0xFFFFFF88, err=0.
REQ-036 Same word; load half addr=0x014, sign_ext=0 -> rdata=0x0000AABB; rdata unchanged after a following store.
REQ-037 Store byte 0x5A at addr=0x015 -> READ then WRITE with mem_addr=5, ready at cycle 3, RAM[5]=0x8899 5ABB.
REQ-038 Store word addr=0x012 -> ready 1 cycle later with err=1, mem_cs never asserted, RAM unchanged; size=11 gives the same result.
REQ-039 Store word 0xDEADBEEF at addr=0x020 with Rst pulsed low during WRITE -> RAM[8] unchanged, all outputs at reset values, no ready pulse.
REQ-040 req held high continuously with back-to-back loads -> one acceptance per 3 cycles, busy=1 except in IDLE, and mem_data never driven while mem_rw=0.
